// File: rtl/button_pulser.sv
// Two-channel push-button conditioner: synchronise, debounce, emit press pulses.
// Optional long-press detection is compiled in with BUTTON_PULSER_LONG_PRESS_EN;
// without it LONG_A/LONG_B are tied low and no hold counters exist.

// One button channel: polarity normalise, 2-flop sync, debounce, edge pulses.
module button_pulser_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn,
  output logic pulse,
  output logic level,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pressed_c;
  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             commit_c;
  logic             pulse_q;

  // Normalise so that 1 always means "pressed".
  assign pressed_c = (ACTIVE_LOW != 0) ? ~btn : btn;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pressed_c;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: count while the synced value disagrees, commit on the last count.
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    commit_c = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d  = sync2_q;
      cnt_d    = '0;
      commit_c = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state and press pulse registers; pulse only on an accepted 0->1.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= commit_c & sync2_q;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

`ifdef BUTTON_PULSER_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q;
  logic              long_q;

  // Hold counter: runs while pressed, saturates at LONG_CYCLES, clears on release.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else if (!level_q) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else if (hold_q != HOLD_MAX) begin
      hold_q <= hold_q + HOLD_W'(1);
      long_q <= (hold_q == HOLD_PRE);
    end else begin
      long_q <= 1'b0;
    end
  end

  assign long_pulse = long_q;
`else
  // Long-press disabled: constant low; LONG_CYCLES stays referenced so both builds share one parameter set.
  assign long_pulse = 1'b0 && (LONG_CYCLES != 0);
`endif

endmodule

// Top level: two fully independent button channels.
module button_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic BTN_A,
  input  logic BTN_B,
  output logic PULSE_A,
  output logic PULSE_B,
  output logic LEVEL_A,
  output logic LEVEL_B,
  output logic LONG_A,
  output logic LONG_B
);

  button_pulser_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_chan_a (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn       (BTN_A),
    .pulse     (PULSE_A),
    .level     (LEVEL_A),
    .long_pulse(LONG_A)
  );

  button_pulser_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_chan_b (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn       (BTN_B),
    .pulse     (PULSE_B),
    .level     (LEVEL_B),
    .long_pulse(LONG_B)
  );

endmodule

// File: tb/tb_button_pulser.sv
// Self-checking bench for button_pulser (DEBOUNCE_CYCLES=4, LONG_CYCLES=8, ACTIVE_LOW=1).
// Expected pulse events are queued with their absolute cycle when stimulus is driven.
module tb_button_pulser;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 8;

  localparam logic [3:0] PA = 4'b0001;
  localparam logic [3:0] PB = 4'b0010;
  localparam logic [3:0] LA = 4'b0100;
  localparam logic [3:0] LB = 4'b1000;

  typedef struct {
    logic [3:0] vec;
    int         cyc;
  } ev_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic BTN_A;
  logic BTN_B;
  logic PULSE_A;
  logic PULSE_B;
  logic LEVEL_A;
  logic LEVEL_B;
  logic LONG_A;
  logic LONG_B;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  ev_t exp_q[$];

  button_pulser #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .BTN_A  (BTN_A),
    .BTN_B  (BTN_B),
    .PULSE_A(PULSE_A),
    .PULSE_B(PULSE_B),
    .LEVEL_A(LEVEL_A),
    .LEVEL_B(LEVEL_B),
    .LONG_A (LONG_A),
    .LONG_B (LONG_B)
  );

  always #5 clk_in = ~clk_in;

  // Absolute rising-edge count; an edge numbered k is observed at the following negedge with cyc == k.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push(input logic [3:0] v, input int c);
    ev_t e;
    e.vec = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_long(input logic [3:0] v, input int c);
`ifdef BUTTON_PULSER_LONG_PRESS_EN
    push(v, c);
`else
    if (v == 4'b0 && c < 0) push(v, c);
`endif
  endtask

  // Monitor: every pulse must match the queue head in both channel set and cycle.
  initial begin : monitor
    logic [3:0] obs;
    ev_t        e;
    forever begin
      @(negedge clk_in);
      obs = {LONG_B, LONG_A, PULSE_B, PULSE_A};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missed_event", 32'(0), 32'(e.vec));
      end
      if (obs != 4'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'(obs), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pulse_vec", 32'(obs), 32'(e.vec));
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin : stim
    int c;
    int d;
    rst_in = 1'b1;
    BTN_A  = 1'b1;
    BTN_B  = 1'b1;

    // Reset state
    tick(3);
    chk("reset_outputs", 32'({LEVEL_B, LEVEL_A, LONG_B, LONG_A, PULSE_B, PULSE_A}), 32'(0));
    rst_in = 1'b0;
    tick(10);
    chk("idle_levels", 32'({LEVEL_B, LEVEL_A}), 32'(0));

    // Single held press on A: level and pulse on relative edge 5
    c = cyc;
    BTN_A = 1'b0;
    push(PA, c + 6);
    push_long(LA, c + 6 + LONG);
    tick(5);
    chk("t1_level_before", 32'(LEVEL_A), 32'(0));
    tick(1);
    chk("t1_level_after", 32'(LEVEL_A), 32'(1));
    chk("t1_pulse", 32'(PULSE_A), 32'(1));
    tick(1);
    chk("t1_pulse_end", 32'(PULSE_A), 32'(0));
    tick(40);
    BTN_A = 1'b1;
    tick(5);
    chk("t1_release_level_hold", 32'(LEVEL_A), 32'(1));
    tick(1);
    chk("t1_release_level_fall", 32'(LEVEL_A), 32'(0));
    tick(10);

    // Three-cycle glitch: never accepted
    BTN_A = 1'b0;
    tick(3);
    BTN_A = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("t2_glitch_level", 32'(LEVEL_A), 32'(0));
    end

    // Four-cycle press: the shortest one accepted
    c = cyc;
    BTN_A = 1'b0;
    push(PA, c + 6);
    tick(4);
    BTN_A = 1'b1;
    tick(2);
    chk("t3_short_level_rise", 32'(LEVEL_A), 32'(1));
    tick(3);
    chk("t3_short_level_hold", 32'(LEVEL_A), 32'(1));
    tick(1);
    chk("t3_short_level_fall", 32'(LEVEL_A), 32'(0));
    tick(10);

    // Both buttons on the same edge
    c = cyc;
    BTN_A = 1'b0;
    BTN_B = 1'b0;
    push(PA | PB, c + 6);
    push_long(LA | LB, c + 6 + LONG);
    tick(20);
    BTN_A = 1'b1;
    BTN_B = 1'b1;
    tick(12);

    // B held 100 cycles: one pulse, no pulse on release
    c = cyc;
    BTN_B = 1'b0;
    push(PB, c + 6);
    push_long(LB, c + 6 + LONG);
    tick(100);
    BTN_B = 1'b1;
    tick(5);
    chk("t5_release_level_hold", 32'(LEVEL_B), 32'(1));
    tick(1);
    chk("t5_release_level_fall", 32'(LEVEL_B), 32'(0));
    tick(10);

    // Reset mid-press on A: re-detected as a new press
    c = cyc;
    BTN_A = 1'b0;
    push(PA, c + 6);
    tick(7);
    rst_in = 1'b1;
    tick(1);
    chk("t6_in_reset_1", 32'({LEVEL_A, LONG_A, PULSE_A}), 32'(0));
    tick(1);
    chk("t6_in_reset_2", 32'({LEVEL_A, LONG_A, PULSE_A}), 32'(0));
    rst_in = 1'b0;
    d = cyc;
    push(PA, d + 6);
    push_long(LA, d + 6 + LONG);
    tick(5);
    chk("t6_level_before", 32'(LEVEL_A), 32'(0));
    tick(1);
    chk("t6_level_after", 32'(LEVEL_A), 32'(1));
    tick(20);
    BTN_A = 1'b1;
    tick(12);

    // Reset on the edge B would pulse: the pulse is suppressed
    c = cyc;
    BTN_B = 1'b0;
    tick(5);
    rst_in = 1'b1;
    tick(1);
    chk("t7_reset_kills_pulse", 32'({LEVEL_B, PULSE_B}), 32'(0));
    rst_in = 1'b0;
    d = cyc;
    push(PB, d + 6);
    push_long(LB, d + 6 + LONG);
    tick(20);
    BTN_B = 1'b1;
    tick(12);

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_pulser.md
BUTTON_PULSER -- requirements
Module: button_pulser

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000, stable-sample count required to accept a level change (>=2).
REQ-002 Parameter LONG_CYCLES, default 12000000, debounced-high cycles before a long-press pulse (>=1).
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = raw buttons read 0 when pressed.
REQ-004 clk_in  input  1  single system clock; all logic on rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-high.
REQ-006 BTN_A, BTN_B  input  1 each  raw asynchronous push-button pins.
REQ-007 PULSE_A, PULSE_B  output  1 each  one-cycle press pulse, registered; drives the stopwatch state machine inputs.
REQ-008 LEVEL_A, LEVEL_B  output  1 each  debounced pressed level, registered.
REQ-009 LONG_A, LONG_B  output  1 each  one-cycle long-press pulse, registered.

Function
REQ-010 Each channel SHALL normalise the raw pin to pressed=1 (invert when ACTIVE_LOW=1) before a 2-flop synchroniser.
REQ-011 Channels A and B SHALL be fully independent; no priority or lockout between them.
REQ-012 Counter SHALL clear whenever the synchronised value equals LEVEL_x, and SHALL increment by 1 when it differs.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and the synchronised value still differs, LEVEL_x SHALL take the synchronised value and the counter SHALL clear, same edge.
REQ-014 Latency: raw change first sampled at edge 0 and held -> LEVEL_x updates on edge DEBOUNCE_CYCLES+1.
REQ-015 Any reversion shorter than the debounce window SHALL restart the count from 0; LEVEL_x SHALL not change.
REQ-016 PULSE_x SHALL be high exactly one cycle, on the same edge LEVEL_x goes 0->1; release (1->0) SHALL produce no pulse.
REQ-017 Holding a button indefinitely SHALL yield exactly one PULSE_x.
REQ-018 Both buttons accepted on the same edge SHALL assert PULSE_A and PULSE_B in the same cycle.
REQ-019 Counter width SHALL be clog2(DEBOUNCE_CYCLES); it SHALL never wrap (cleared on commit or match).

Reset
REQ-020 While rst_in=1 on an edge: synchroniser flops, LEVEL_x, PULSE_x, LONG_x and all counters SHALL be 0.
REQ-021 Reset mid-press: a button still held after rst_in deasserts SHALL be treated as a new press and produce one PULSE_x after the REQ-014 latency.
REQ-022 Reset asserted during a pulse cycle SHALL force PULSE_x/LONG_x to 0 on that edge.

Configuration
REQ-023 Macro BUTTON_PULSER_LONG_PRESS_EN defined: a per-channel hold counter SHALL count while LEVEL_x=1, clear when LEVEL_x=0, and assert LONG_x for one cycle when it reaches LONG_CYCLES; saturate afterwards (no repeat until release).
REQ-024 Macro undefined: hold counters SHALL not be built; LONG_A/LONG_B SHALL be constant 0; ports remain.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=8, ACTIVE_LOW=1)
REQ-025 BTN_A 1->0 sampled at edge 0, held -> LEVEL_A=1 and PULSE_A=1 after edge 5 only; PULSE_A=0 after edge 6.
REQ-026 BTN_A low for 3 cycles then high -> LEVEL_A and PULSE_A stay 0 throughout.
REQ-027 BTN_A and BTN_B low same edge, held -> PULSE_A and PULSE_B both 1 in the same single cycle.
REQ-028 BTN_B held low 100 cycles then released -> exactly one PULSE_B; LEVEL_B returns 0 five edges after release; no pulse on release.
REQ-029 BTN_A held; rst_in high 2 cycles after PULSE_A, then low -> outputs 0 during reset; second PULSE_A 5 edges after rst_in deasserts.
REQ-030 With BUTTON_PULSER_LONG_PRESS_EN, BTN_A held -> LONG_A one cycle, 8 cycles after LEVEL_A rises, never again while held; without macro LONG_A stays 0.
